// File: rtl/riscv_boot_dump_ctrl_pkg.sv
// riscv_harness_pkg: shared state encoding and opcode constants for the boot/dump controller
package riscv_harness_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, RDREQ, DUMP, DONE} state_t;
  localparam logic [5:0] HLT_OPCODE = 6'b111111;
endpackage

// File: rtl/riscv_boot_dump_ctrl_if.sv
// riscv_boot_dump_ctrl_if: load and dump stream handshakes between host and controller
interface riscv_boot_dump_ctrl_if #(parameter int XLEN = 32, parameter int RW = 5);
  logic ld_valid;
  logic ld_ready;
  logic [XLEN-1:0] ld_data;
  logic ld_last;
  logic dump_valid;
  logic dump_ready;
  logic [RW-1:0] dump_idx;
  logic [XLEN-1:0] dump_data;
  logic dump_last;
  modport master (output ld_valid, ld_data, ld_last, dump_ready,
                  input ld_ready, dump_valid, dump_idx, dump_data, dump_last);
  modport slave (input ld_valid, ld_data, ld_last, dump_ready,
                 output ld_ready, dump_valid, dump_idx, dump_data, dump_last);
endinterface

// File: rtl/riscv_boot_dump_ctrl_rf_dump_seq.sv
// rf_dump_seq: register-file read index and dump output hold register
module rf_dump_seq #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  localparam int RW = $clog2(NREGS)
) (
  input  logic clk1,
  input  logic rst,
  input  logic rd,
  input  logic dp,
  input  logic [XLEN-1:0] rf_rdata,
  input  logic dump_ready,
  output logic [RW-1:0] rf_raddr,
  output logic dump_valid,
  output logic [RW-1:0] dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic dump_last,
  output logic hs,
  output logic last
);
  logic [RW-1:0] idx;
  logic vld;
  logic [XLEN-1:0] data;
  assign last = idx == RW'(NREGS - 1);
  assign hs = vld && dump_ready;
  assign rf_raddr = idx;
  assign dump_idx = idx;
  assign dump_valid = vld;
  assign dump_data = data;
  assign dump_last = vld && last;
  // first DUMP cycle captures the synchronous read data, later cycles hold it
  always_ff @(posedge clk1)
    if (rst || !(rd || dp)) begin
      idx <= '0;
      vld <= 1'b0;
      data <= '0;
    end else if (dp) begin
      if (!vld) begin
        data <= rf_rdata;
        vld <= 1'b1;
      end else if (dump_ready) begin
        vld <= 1'b0;
        if (!last) idx <= idx + 1'b1;
      end
    end
endmodule

// File: rtl/riscv_boot_dump_ctrl.sv
// riscv_boot_dump_ctrl: program load, bounded core run and register dump sequencer
// RISCV_HALT_DETECT_EN: end RUN early when the core retires HLT
module riscv_boot_dump_ctrl
  import riscv_harness_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int NREGS = 32,
  parameter int RUN_W = 16,
  localparam int AW = $clog2(IMEM_DEPTH),
  localparam int RW = $clog2(NREGS)
) (
  input  logic clk1,
  input  logic rst,
  input  logic cmd_start,
  input  logic [RUN_W-1:0] run_cycles,
  riscv_boot_dump_ctrl_if.slave bus,
  output logic imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic core_rst,
  input  logic retire_valid,
  input  logic [XLEN-1:0] retire_instr,
  output logic [RW-1:0] rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic busy,
  output logic done,
  output logic err_overflow,
  output logic [RUN_W-1:0] cycles_used
);
  state_t st, nx;
  logic [AW-1:0] ptr;
  logic [RUN_W-1:0] bud, cnt, cnt_n;
  logic err, ld_hs, ptr_end, go, halt, run_end, dhs, dlast, unused_retire;
`ifdef RISCV_HALT_DETECT_EN
  assign halt = retire_valid && retire_instr[31:26] == HLT_OPCODE;
  assign unused_retire = ^retire_instr[25:0];
`else
  assign halt = 1'b0;
  assign unused_retire = ^{retire_valid, retire_instr};
`endif
  assign go = (st == IDLE || st == DONE) && cmd_start;
  assign ld_hs = st == LOAD && bus.ld_valid;
  assign ptr_end = ptr == AW'(IMEM_DEPTH - 1);
  assign cnt_n = cnt + 1'b1;
  assign run_end = cnt_n == bud || halt;
  assign bus.ld_ready = st == LOAD;
  assign imem_we = ld_hs;
  assign imem_addr = ptr;
  assign imem_wdata = st == LOAD ? bus.ld_data : '0;
  assign core_rst = st != RUN;
  assign busy = st != IDLE && st != DONE;
  assign done = st == DONE;
  assign err_overflow = err;
  assign cycles_used = cnt;
  always_comb begin
    nx = st;
    case (st)
      IDLE, DONE: nx = cmd_start ? LOAD : st;
      LOAD: if (ld_hs) nx = bus.ld_last ? (bud == '0 ? RDREQ : RUN) : (ptr_end ? DONE : LOAD);
      RUN: nx = run_end ? RDREQ : RUN;
      RDREQ: nx = DUMP;
      DUMP: if (dhs) nx = dlast ? DONE : RDREQ;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk1)
    if (rst) begin
      st <= IDLE;
      ptr <= '0;
      bud <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      st <= nx;
      if (go) begin
        bud <= run_cycles;
        ptr <= '0;
        cnt <= '0;
        err <= 1'b0;
      end
      if (ld_hs) ptr <= ptr + 1'b1;
      if (ld_hs && !bus.ld_last && ptr_end) err <= 1'b1;
      if (st == RUN) cnt <= cnt_n;
    end
  rf_dump_seq #(.XLEN(XLEN), .NREGS(NREGS)) u_seq (
    .clk1(clk1),
    .rst(rst),
    .rd(st == RDREQ),
    .dp(st == DUMP),
    .rf_rdata(rf_rdata),
    .dump_ready(bus.dump_ready),
    .rf_raddr(rf_raddr),
    .dump_valid(bus.dump_valid),
    .dump_idx(bus.dump_idx),
    .dump_data(bus.dump_data),
    .dump_last(bus.dump_last),
    .hs(dhs),
    .last(dlast)
  );
endmodule

// File: tb/tb_riscv_boot_dump_ctrl.sv
// tb_riscv_boot_dump_ctrl: directed bench with a stub core for the boot/dump controller
module tb_riscv_boot_dump_ctrl;
  logic clk1 = 1'b0, rst = 1'b1, cmd_start = 1'b0, cmd_start8 = 1'b0;
  logic [15:0] run_cycles = '0;
  always #5 clk1 = ~clk1;

  riscv_boot_dump_ctrl_if #(.XLEN(32), .RW(5)) bus();
  riscv_boot_dump_ctrl_if #(.XLEN(32), .RW(5)) bus8();

  logic imem_we, core_rst, retire_valid, busy, done, err_overflow;
  logic [9:0] imem_addr;
  logic [31:0] imem_wdata, retire_instr, rf_rdata;
  logic [4:0] rf_raddr;
  logic [15:0] cycles_used;
  logic imem_we8, core_rst8, busy8, done8, err8;
  logic [2:0] imem_addr8;
  logic [31:0] imem_wdata8;
  logic [4:0] rf_raddr8;
  logic [15:0] cu8;

  riscv_boot_dump_ctrl dut (
    .clk1(clk1), .rst(rst), .cmd_start(cmd_start), .run_cycles(run_cycles), .bus(bus),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .retire_valid(retire_valid), .retire_instr(retire_instr), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .busy(busy), .done(done), .err_overflow(err_overflow),
    .cycles_used(cycles_used));

  riscv_boot_dump_ctrl #(.IMEM_DEPTH(8)) u_ovf (
    .clk1(clk1), .rst(rst), .cmd_start(cmd_start8), .run_cycles(16'd5), .bus(bus8),
    .imem_we(imem_we8), .imem_addr(imem_addr8), .imem_wdata(imem_wdata8), .core_rst(core_rst8),
    .retire_valid(1'b0), .retire_instr(32'd0), .rf_raddr(rf_raddr8),
    .rf_rdata(32'd0), .busy(busy8), .done(done8), .err_overflow(err8),
    .cycles_used(cu8));

  // stub core: op[31:26] rd[25:21] rs[20:16] rt[15:11] imm[15:0]; 1=ADDI 2=ADD 3=OR
  logic [31:0] mem [0:1023];
  logic [31:0] regs [0:31];
  logic [9:0] pc;
  logic [31:0] ins;
  assign ins = mem[pc];
  assign retire_valid = !core_rst;
  assign retire_instr = ins;
  always @(posedge clk1) begin
    if (rst) begin
      pc <= '0;
      rf_rdata <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (imem_we) mem[imem_addr] <= imem_wdata;
      if (core_rst) pc <= '0;
      else begin
        pc <= pc + 10'd1;
        if (ins[25:21] != 5'd0)
          case (ins[31:26])
            6'd1: regs[ins[25:21]] <= regs[ins[20:16]] + {{16{ins[15]}}, ins[15:0]};
            6'd2: regs[ins[25:21]] <= regs[ins[20:16]] + regs[ins[15:11]];
            6'd3: regs[ins[25:21]] <= regs[ins[20:16]] | regs[ins[15:11]];
            default: ;
          endcase
      end
      rf_rdata <= regs[rf_raddr];
    end
  end

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int beats, lows, stall_bad, nlast, low_first, dv_first, lastw;
  logic [4:0] bidx [0:63];
  logic [31:0] bdat [0:63];
  logic pv, pr, pl;
  logic [4:0] pi;
  logic [31:0] pd;
  always @(negedge clk1) begin
    if (cmd_start) begin
      beats <= 0; lows <= 0; stall_bad <= 0; nlast <= 0;
      low_first <= -1; dv_first <= -1; lastw <= -1;
    end else begin
      if (!core_rst) begin
        lows <= lows + 1;
        if (low_first < 0) low_first <= cyc;
      end
      if (bus.dump_valid && dv_first < 0) dv_first <= cyc;
      if (imem_we && bus.ld_last) lastw <= cyc;
      if (bus.dump_valid && bus.dump_ready) begin
        if (beats < 64) begin
          bidx[beats[5:0]] <= bus.dump_idx;
          bdat[beats[5:0]] <= bus.dump_data;
        end
        beats <= beats + 1;
        if (bus.dump_last) nlast <= nlast + 1;
      end
      if (!rst && pv && !pr && (!bus.dump_valid || bus.dump_idx != pi ||
          bus.dump_data != pd || bus.dump_last != pl))
        stall_bad <= stall_bad + 1;
    end
    pv <= bus.dump_valid; pr <= bus.dump_ready; pi <= bus.dump_idx;
    pd <= bus.dump_data; pl <= bus.dump_last;
  end

  int w8, l8, dv8;
  logic [2:0] la8;
  always @(negedge clk1)
    if (cmd_start8) begin
      w8 <= 0; l8 <= 0; dv8 <= 0;
    end else begin
      if (imem_we8) begin
        w8 <= w8 + 1;
        la8 <= imem_addr8;
      end
      if (!core_rst8) l8 <= l8 + 1;
      if (bus8.dump_valid) dv8 <= dv8 + 1;
    end

  int checks = 0, failures = 0;
  logic [31:0] pg [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.dump_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [15:0] rc);
    run_cycles = rc; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1; bus.ld_data = pg[i]; bus.ld_last = (i == n - 1);
      if (i == 0) begin
        @(negedge clk1);
        chk("ld_ready", bus.ld_ready, 1);
        chk("imem_we", imem_we, 1);
      end
      tick();
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) tick();
    chk("done", done, 1);
  endtask

  task automatic check_rst(input string nm);
    @(negedge clk1);
    chk({nm, "_flags"}, {busy, done, core_rst, bus.ld_ready, imem_we, bus.dump_valid,
        bus.dump_last, err_overflow}, 8'b0010_0000);
    chk({nm, "_addr"}, {cycles_used, imem_addr, rf_raddr, bus.dump_idx}, 0);
    chk({nm, "_data"}, {imem_wdata, bus.dump_data}, 0);
  endtask

  task automatic check_dump(input string nm);
    int e = 0;
    for (int j = 0; j < 32; j++) if (bidx[j] != 5'(j)) e++;
    chk({nm, "_beats"}, beats, 32);
    chk({nm, "_idx_seq"}, e, 0);
    chk({nm, "_nlast"}, nlast, 1);
    chk({nm, "_stall"}, stall_bad, 0);
  endtask

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rd, rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction

  task automatic main_prog();
    pg[0] = ri(6'd1, 5'd1, 5'd0, 16'd10);
    pg[1] = ri(6'd1, 5'd2, 5'd0, 16'd20);
    pg[2] = ri(6'd1, 5'd3, 5'd0, 16'd25);
    for (int i = 3; i < 9; i++) pg[i] = rr(6'd3, 5'd0, 5'd0, 5'd0);
    pg[6] = rr(6'd2, 5'd4, 5'd1, 5'd2);
    pg[9] = rr(6'd2, 5'd5, 5'd4, 5'd3);
  endtask

  typedef struct { logic [15:0] rc; int lows; int lat; logic [31:0] r1, r4, r5; } sc_t;
  typedef struct { logic [4:0] idx; logic [31:0] val; } rv_t;
  sc_t sc [4];
  rv_t rv [7];

  task automatic check_regs(input string nm);
    for (int i = 0; i < 7; i++)
      chk($sformatf("%s_r%0d", nm, rv[i].idx), bdat[rv[i].idx], rv[i].val);
  endtask

  initial begin
    sc[0] = '{16'd40, 40, 43, 32'd10, 32'd30, 32'd55};
    sc[1] = '{16'd0, 0, 3, 32'd0, 32'd0, 32'd0};
    sc[2] = '{16'd1, 1, 4, 32'd10, 32'd0, 32'd0};
    sc[3] = '{16'd9, 9, 12, 32'd10, 32'd30, 32'd0};
    rv[0] = '{5'd1, 32'd10}; rv[1] = '{5'd2, 32'd20}; rv[2] = '{5'd3, 32'd25};
    rv[3] = '{5'd4, 32'd30}; rv[4] = '{5'd5, 32'd55}; rv[5] = '{5'd0, 32'd0};
    rv[6] = '{5'd31, 32'd0};
    bus.ld_data = '0; bus8.ld_valid = 1'b0; bus8.ld_data = '0; bus8.ld_last = 1'b0;
    bus8.dump_ready = 1'b1;
    do_reset();
    check_rst("por");

    for (int i = 0; i < 4; i++) begin
      do_reset();
      main_prog();
      start(sc[i].rc);
      load(10);
      wait_done(3000);
      chk($sformatf("sc%0d_used", i), cycles_used, sc[i].rc);
      chk($sformatf("sc%0d_lows", i), lows, sc[i].lows);
      chk($sformatf("sc%0d_lat", i), dv_first - lastw, sc[i].lat);
      chk($sformatf("sc%0d_busy", i), busy, 0);
      chk($sformatf("sc%0d_r1", i), bdat[1], sc[i].r1);
      chk($sformatf("sc%0d_r4", i), bdat[4], sc[i].r4);
      chk($sformatf("sc%0d_r5", i), bdat[5], sc[i].r5);
      check_dump($sformatf("sc%0d", i));
      if (i == 0) check_regs("main");
    end

    do_reset();
    main_prog();
    start(16'd20);
    load(10);
    for (int i = 0; i < 4000 && !done; i++) begin
      bus.dump_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.dump_ready = 1'b1;
    chk("thr_done", done, 1);
    check_dump("thr");
    check_regs("thr");

    for (int i = 0; i < 11; i++) pg[i] = rr(6'd3, 5'd0, 5'd0, 5'd0);
    pg[11] = 32'hfc000000;
    do_reset();
    start(16'd100);
    load(12);
    wait_done(3000);
`ifdef RISCV_HALT_DETECT_EN
    chk("hlt_used", cycles_used, 12);
    chk("hlt_lows", lows, 12);
`else
    chk("hlt_used", cycles_used, 100);
    chk("hlt_lows", lows, 100);
`endif

    cmd_start8 = 1'b1;
    tick();
    cmd_start8 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus8.ld_valid = 1'b1; bus8.ld_data = 32'(i + 1);
      tick();
    end
    bus8.ld_valid = 1'b0;
    tick();
    chk("ovf_writes", w8, 8);
    chk("ovf_lastaddr", la8, 7);
    chk("ovf_err", err8, 1);
    chk("ovf_done", {done8, busy8}, 2'b10);
    chk("ovf_core_low", l8, 0);
    chk("ovf_dump", dv8, 0);
    cmd_start8 = 1'b1;
    tick();
    cmd_start8 = 1'b0;
    chk("ovf_restart", {err8, busy8, bus8.ld_ready}, 3'b011);

    do_reset();
    main_prog();
    start(16'd40);
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_data = pg[i];
      tick();
    end
    rst = 1'b1; bus.ld_data = 32'hdeadbeef;
    tick();
    check_rst("rst_load");
    rst = 1'b0; bus.ld_valid = 1'b0;
    tick();
    chk("rst_load_idle", {busy, done}, 0);

    start(16'd5);
    load(10);
    for (int i = 0; i < 500 && !(bus.dump_valid && bus.dump_idx == 5'd3); i++) tick();
    chk("dump_reach", {bus.dump_valid, bus.dump_idx}, {1'b1, 5'd3});
    rst = 1'b1;
    tick();
    check_rst("rst_dump");
    rst = 1'b0;
    start(16'd40);
    load(10);
    wait_done(3000);
    chk("fresh_used", cycles_used, 40);
    check_dump("fresh");
    check_regs("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_boot_dump_ctrl.md
# riscv_boot_dump_ctrl

Synthesizable program-load / run / register-dump controller for the RISC pipeline, replacing hierarchical memory pokes and fixed-delay register printing with a parametrised, handshaked sequence. It streams a program into instruction memory and holds the core in reset while loading. It then releases the core for a bounded cycle budget, stopping early on HLT when configured. Finally it re-asserts core reset and streams every register-file entry out. It sits between a host/bench stream port and the core's instruction memory write port, reset input and register-file debug read port.

## Interface
- XLEN, 32, instruction/register data width
- IMEM_DEPTH, 1024, instruction memory words; AW = clog2(IMEM_DEPTH)
- NREGS, 32, register-file entries dumped; RW = clog2(NREGS)
- RUN_W, 16, cycle-budget counter width
- clk1  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_start  in  1  start pulse; sampled only in IDLE and DONE
- run_cycles  in  RUN_W  cycle budget, latched on accepted cmd_start
- ld_valid / ld_ready  in / out  1  load-stream handshake
- ld_data  in  XLEN  instruction word
- ld_last  in  1  marks the final word of the program
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  XLEN  write data
- core_rst  out  1  active-high hold of the pipeline
- retire_valid  in  1  core retired an instruction (used only with the macro)
- retire_instr  in  XLEN  retired instruction word (used only with the macro)
- rf_raddr  out  RW  register-file debug read address; read data valid one cycle later
- rf_rdata  in  XLEN  register-file debug read data
- dump_valid / dump_ready  out / in  1  dump-stream handshake
- dump_idx  out  RW  register index of dump_data
- dump_data  out  XLEN  register value
- dump_last  out  1  asserted with index NREGS-1
- busy  out  1  asserted in any state other than IDLE and DONE
- done  out  1  asserted in DONE
- err_overflow  out  1  sticky load-overflow flag
- cycles_used  out  RUN_W  number of cycles core_rst was low in the last RUN

## Operation
- States: IDLE, LOAD, RUN, RDREQ, DUMP, DONE.
- IDLE or DONE + cmd_start: latch run_cycles, clear ptr, cycles_used and err_overflow, go to LOAD.
- LOAD:
  - ld_ready=1; imem_we = ld_valid&ld_ready (combinational); imem_addr=ptr; imem_wdata=ld_data.
  - Each handshake increments ptr.
  - Accepted word with ld_last goes to RUN.
  - Accepted word at ptr=IMEM_DEPTH-1 without ld_last: word is written, err_overflow set, go to DONE with no RUN or dump.
- RUN:
  - core_rst=0; counter increments each cycle.
  - Exit when count equals the latched budget; the exit then goes to RDREQ with index 0.
  - A latched budget of 0 skips RUN: core_rst stays 1 and the next state is RDREQ.
- RDREQ: drive rf_raddr=idx for one cycle, then go to DUMP.
- DUMP:
  - Capture rf_rdata into dump_data and hold dump_valid until dump_ready.
  - On handshake: if idx=NREGS-1 go to DONE, else idx++ and go to RDREQ.
- DONE: done=1; a new cmd_start reruns from LOAD with imem contents overwritten from address 0.
- Reset values: state IDLE, core_rst=1, ld_ready=0, imem_we=0, dump_valid=0, busy=0, done=0, err_overflow=0, cycles_used=0, all addresses and data 0.
- core_rst is 1 in every state except RUN.
- rst mid-operation, in any state: the state returns to IDLE on the next edge and any partial dump is abandoned.
- cmd_start while busy: ignored.

## Timing
- cmd_start at edge t: LOAD and ld_ready=1 from t+1.
- Load throughput: one word per cycle.
- Last word accepted at cycle c: core_rst=0 from c+1 for exactly run_cycles cycles.
- After RUN ends: first dump_valid 2 cycles after core_rst rises.
- Dump rate: at most one register per 2 cycles, and only while dump_ready is held high.
- dump_data, dump_idx and dump_last are stable while dump_valid=1 and dump_ready=0.

## Configuration
- RISCV_HALT_DETECT_EN defined: in RUN, retire_valid with retire_instr[31:26]=6'b111111 (HLT) ends RUN.
  - core_rst=1 on the next cycle; cycles_used equals the count including the HLT cycle.
  - HLT and budget expiry in the same cycle: treated as a single exit.
- Macro undefined: the retire inputs are unused and RUN always lasts run_cycles cycles.

## Structure
- Package riscv_harness_pkg: state enum; HLT_OPCODE constant (6'b111111).
- Sub-module rf_dump_seq owns the RDREQ/DUMP index counter and the output hold register; the top holds the FSM, the load pointer and the run counter.

## Test plan
- Load 10 words (ADDI R1,10; ADDI R2,20; ADDI R3,25; 3×OR filler; ADD R4,R1,R2; 2×OR; ADD R5,R4,R3) with run_cycles=40 and dump_ready=1.
  - Required: dump gives R1=10, R2=20, R3=25, R4=30, R5=55, R0=0.
  - Required: 32 beats, dump_last on idx 31, cycles_used=40.
- Throttled dump: dump_ready toggled randomly during the dump.
  - Required: no duplicated or skipped indices; dump_data stable while stalled.
- Overflow: IMEM_DEPTH=8, stream 9 words with no ld_last.
  - Required: 8 writes, err_overflow=1, DONE with core_rst never low.
- run_cycles=0.
  - Required: core_rst never drops; dump begins immediately after load.
- With RISCV_HALT_DETECT_EN: HLT (32'hfc000000) retired at RUN cycle 12 with budget 100.
  - Required: core_rst=1 next cycle, cycles_used=12.
- rst asserted mid-LOAD and again mid-DUMP.
  - Required: IDLE next edge, core_rst=1, all outputs at reset values; a fresh cmd_start then completes normally.
